vector_frame_tx: RTL and testbench

- Transmit side of the vector-display serial link.
- Reads a point list from a synchronous point RAM and serialises it over UART 8N1, framed exactly as the display-side receive buffer expects:
  - 8 sync bytes 0x00,
  - then 4 bytes per point, MSB first,
  - then terminator 0x01 0x01 0x01 0x01.
- Used by the host-side or loopback test FPGA to stream frames to the display board.

---
 rtl/vector_frame_tx.sv | 200 ++++++++++++++++++++
 tb/tb_vector_frame_tx.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/vector_frame_tx.sv
// Vector-display link transmitter: streams a point RAM over UART 8N1 as 8x 0x00 sync,
// 4 bytes per point (MSB first), then 4x 0x01. Optional: VECTOR_TX_SKIP_MARKER_EN.
module vector_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned MAX_PTS      = 2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] num_pts,
  output logic [10:0] rd_index,
  input  logic [31:0] point,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned   CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [10:0]   MAX_N    = 11'(MAX_PTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_POINT,
    S_TERM,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [10:0]   n_q, n_d;
  logic [10:0]   pt_q, pt_d;
  logic [10:0]   rd_index_q, rd_index_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [23:0]   sh_q, sh_d;
  logic          rd_wait_q, rd_wait_d;

  logic          u_active_q, u_active_d;
  logic [9:0]    u_sh_q, u_sh_d;
  logic [3:0]    u_bit_q, u_bit_d;
  logic [CW-1:0] u_clk_q, u_clk_d;

  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          u_ready;
  logic          last_pt;
  logic          skip;

  // The engine accepts a new byte in the last cycle of a stop bit, so bytes run back to back.
  assign u_ready = !u_active_q || (u_bit_q == 4'd9 && u_clk_q == BIT_LAST);
  assign last_pt = (pt_q == n_q - 11'd1);

`ifdef VECTOR_TX_SKIP_MARKER_EN
  localparam logic [31:0] MARKER = 32'h0101_0101;
  // rd_wait_q masks the one stale RAM cycle after rd_index moves.
  assign skip = !rd_wait_q && (point == MARKER);
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    pt_d       = pt_q;
    rd_index_d = rd_index_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rd_wait_d  = 1'b0;
    byte_valid = 1'b0;
    byte_data  = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d        = (num_pts > MAX_N) ? MAX_N : num_pts;
          pt_d       = '0;
          rd_index_d = '0;
          rd_wait_d  = 1'b1;
          cnt_d      = '0;
          state_d    = S_SYNC;
        end
      end
      S_SYNC: begin
        byte_valid = 1'b1;
        if (u_ready) begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            cnt_d   = '0;
            state_d = (n_q != '0) ? S_POINT : S_TERM;
          end
        end
      end
      S_POINT: begin
        if (cnt_q == 3'd0) begin
          if (skip) begin
            if (last_pt) begin
              state_d = S_TERM;
            end else begin
              pt_d       = pt_q + 11'd1;
              rd_index_d = pt_q + 11'd1;
              rd_wait_d  = 1'b1;
            end
          end else begin
            byte_valid = !rd_wait_q;
            byte_data  = point[31:24];
            if (byte_valid && u_ready) begin
              sh_d  = point[23:0];
              cnt_d = 3'd1;
              if (!last_pt) begin
                rd_index_d = pt_q + 11'd1;
                rd_wait_d  = 1'b1;
              end
            end
          end
        end else begin
          byte_valid = 1'b1;
          byte_data  = sh_q[23:16];
          if (u_ready) begin
            sh_d  = {sh_q[15:0], 8'h00};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              cnt_d = '0;
              if (last_pt) state_d = S_TERM;
              else         pt_d    = pt_q + 11'd1;
            end
          end
        end
      end
      S_TERM: begin
        if (cnt_q < 3'd4) begin
          byte_valid = 1'b1;
          byte_data  = 8'h01;
          if (u_ready) cnt_d = cnt_q + 3'd1;
        end else if (u_ready) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    u_active_d = u_active_q;
    u_sh_d     = u_sh_q;
    u_bit_d    = u_bit_q;
    u_clk_d    = u_clk_q;
    if (byte_valid && u_ready) begin
      u_active_d = 1'b1;
      u_sh_d     = {1'b1, byte_data, 1'b0};
      u_bit_d    = '0;
      u_clk_d    = '0;
    end else if (u_active_q) begin
      if (u_clk_q == BIT_LAST) begin
        u_clk_d = '0;
        u_sh_d  = {1'b1, u_sh_q[9:1]};
        if (u_bit_q == 4'd9) u_active_d = 1'b0;
        else                 u_bit_d    = u_bit_q + 4'd1;
      end else begin
        u_clk_d = u_clk_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      pt_q       <= '0;
      rd_index_q <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      rd_wait_q  <= 1'b0;
      u_active_q <= 1'b0;
      u_sh_q     <= '1;
      u_bit_q    <= '0;
      u_clk_q    <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      pt_q       <= pt_d;
      rd_index_q <= rd_index_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rd_wait_q  <= rd_wait_d;
      u_active_q <= u_active_d;
      u_sh_q     <= u_sh_d;
      u_bit_q    <= u_bit_d;
      u_clk_q    <= u_clk_d;
    end
  end

  assign tx       = !u_active_q || u_sh_q[0];
  assign busy     = (state_q == S_SYNC) || (state_q == S_POINT) || (state_q == S_TERM);
  assign done     = (state_q == S_DONE);
  assign rd_index = rd_index_q;

endmodule

// File: tb/tb_vector_frame_tx.sv
// Bench for vector_frame_tx: decodes the tx line sample by sample and compares against
// a byte-list model of the frame built from the RAM contents.
module tb_vector_frame_tx;

  localparam int CPB      = 4;
  localparam int MAXP     = 3;
  localparam int BYTE_CYC = 10 * CPB;
`ifdef VECTOR_TX_SKIP_MARKER_EN
  localparam int MARK_BYTES = 16;
`else
  localparam int MARK_BYTES = 20;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] num_pts;
  logic [10:0] rd_index;
  logic [31:0] point;
  logic        tx, busy, done;

  vector_frame_tx #(.CLKS_PER_BIT(CPB), .MAX_PTS(MAXP)) dut (
    .clk(clk), .reset(reset), .start(start), .num_pts(num_pts), .rd_index(rd_index),
    .point(point), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:7];
  always @(posedge clk) point <= ram[rd_index[2:0]];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input bit ok, input longint act, input longint exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // line sampler, 1 time unit after each active edge
  bit cap = 1'b0;
  bit samp[$];
  int done_cnt, done_idx, busy_err, maxrd;
  bit busy0;
  always begin
    @(posedge clk);
    #1;
    if (cap) begin
      samp.push_back(tx);
      if (samp.size() == 1) busy0 = busy;
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = samp.size() - 1;
        if (busy) busy_err++;
      end
      if (int'(rd_index) > maxrd) maxrd = int'(rd_index);
    end
  end

  logic [7:0] exp_q[$];

  task automatic build_expected(input int n_req);
    int m;
    m = (n_req > MAXP) ? MAXP : n_req;
    exp_q.delete();
    repeat (8) exp_q.push_back(8'h00);
    for (int k = 0; k < m; k++) begin
`ifdef VECTOR_TX_SKIP_MARKER_EN
      if (ram[k] == 32'h0101_0101) continue;
`endif
      for (int b = 3; b >= 0; b--) exp_q.push_back(ram[k][b*8 +: 8]);
    end
    repeat (4) exp_q.push_back(8'h01);
  endtask

  task automatic run_frame(input int n_req, input bit restart, input bit start_at_done,
                           input int exp_nbytes, input int exp_maxrd, input string tag);
    int c, fz, l_exp, terr, berr, bfirst;
    logic [7:0] by, got_first, exp_first;
    bit idle_ok;
    build_expected(n_req);
    @(negedge clk);
    samp.delete();
    done_cnt = 0; done_idx = -1; busy_err = 0; maxrd = 0; busy0 = 1'b0; cap = 1'b1;
    start = 1'b1; num_pts = 11'(n_req);
    @(negedge clk);
    start = 1'b0; num_pts = 11'($urandom);
    c = 0;
    while (done_cnt == 0 && c < 4000) begin
      @(negedge clk);
      start = (restart && c == 150) || (start_at_done && done);
      if (start) num_pts = 11'($urandom);
      c++;
    end
    chk({tag, ":done_seen"}, done_cnt > 0, done_cnt, 1);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk({tag, ":idle_after_done"}, busy == 1'b0, busy, 0);
    cap = 1'b0;

    fz = -1;
    foreach (samp[i]) if (fz < 0 && samp[i] == 1'b0) fz = i;
    chk({tag, ":first_start_bit"}, fz >= 0 && fz <= 2, fz, 1);
    if (fz < 0) fz = 0;
    terr = 0; berr = 0; bfirst = -1; got_first = '0; exp_first = '0;
    for (int b = 0; b < exp_q.size(); b++) begin
      by = '0;
      for (int j = 0; j < 10; j++) begin
        int base;
        bit v0;
        base = fz + b * BYTE_CYC + j * CPB;
        if (base + CPB > samp.size()) begin
          terr++;
          continue;
        end
        v0 = samp[base];
        for (int s = 1; s < CPB; s++) if (samp[base+s] != v0) terr++;
        if (j == 0 && v0 != 1'b0) terr++;
        if (j == 9 && v0 != 1'b1) terr++;
        if (j >= 1 && j <= 8) by[j-1] = v0;
      end
      if (by != exp_q[b]) begin
        berr++;
        if (bfirst < 0) begin bfirst = b; got_first = by; exp_first = exp_q[b]; end
      end
    end
    chk({tag, ":bytes"}, berr == 0, got_first, exp_first);
    chk({tag, ":bit_timing"}, terr == 0, terr, 0);
    idle_ok = 1'b1;
    for (int i = fz + exp_q.size() * BYTE_CYC; i < samp.size(); i++) if (samp[i] != 1'b1) idle_ok = 1'b0;
    chk({tag, ":line_idle_after"}, idle_ok, idle_ok, 1);
    l_exp = exp_nbytes * BYTE_CYC;
    chk({tag, ":frame_len"}, done_idx >= l_exp - 3 && done_idx <= l_exp + 3, done_idx, l_exp);
    chk({tag, ":done_pulses"}, done_cnt == 1, done_cnt, 1);
    chk({tag, ":busy_low_at_done"}, busy_err == 0, busy_err, 0);
    chk({tag, ":busy_after_accept"}, busy0 == 1'b1, busy0, 1);
    chk({tag, ":max_rd_index"}, maxrd == exp_maxrd, maxrd, exp_maxrd);
  endtask

  typedef struct {
    logic [31:0] w0, w1, w2;
    int          n;
    bit          restart;
    bit          sad;
    int          nbytes;
    int          maxrd;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int n, m;
    reset = 1'b1; start = 1'b0; num_pts = '0;
    for (int i = 0; i < 8; i++) ram[i] = '0;
    #3;
    chk("reset:tx", tx == 1'b1, tx, 1);
    chk("reset:busy", busy == 1'b0, busy, 0);
    chk("reset:done", done == 1'b0, done, 0);
    chk("reset:rd_index", rd_index == '0, rd_index, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    vecs[0] = '{32'h00AB_C123, 32'h0FFF_0001, 32'h0, 2, 1'b0, 1'b1, 20, 1};
    vecs[1] = '{32'hFFFF_FFFF, 32'h1234_5678, 32'h0, 0, 1'b0, 1'b0, 12, 0};
    vecs[2] = '{32'h1122_3344, 32'h5566_7788, 32'h99AA_BBCC, 5, 1'b1, 1'b0, 24, 2};
    vecs[3] = '{32'h0101_0101, 32'h0000_0005, 32'h0, 2, 1'b0, 1'b0, MARK_BYTES, 1};
    for (int v = 0; v < 4; v++) begin
      ram[0] = vecs[v].w0; ram[1] = vecs[v].w1; ram[2] = vecs[v].w2;
      run_frame(vecs[v].n, vecs[v].restart, vecs[v].sad, vecs[v].nbytes, vecs[v].maxrd,
                $sformatf("vec%0d", v));
    end

    // reset in the middle of the first point, then a clean frame
    ram[0] = 32'hDEAD_BEEF; ram[1] = 32'h1234_5678;
    @(negedge clk); start = 1'b1; num_pts = 11'd2;
    @(negedge clk); start = 1'b0;
    repeat (8 * BYTE_CYC + 15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid:tx", tx == 1'b1, tx, 1);
    chk("rst_mid:busy", busy == 1'b0, busy, 0);
    chk("rst_mid:done", done == 1'b0, done, 0);
    chk("rst_mid:rd_index", rd_index == '0, rd_index, 0);
    @(negedge clk); reset = 1'b0;
    run_frame(2, 1'b0, 1'b0, 20, 1, "after_rst");

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) ram[k] = ($urandom_range(0, 3) == 0) ? 32'h0101_0101 : $urandom;
      n = $urandom_range(0, 5);
      m = (n > MAXP) ? MAXP : n;
      build_expected(n);
      run_frame(n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), exp_q.size(),
                (m == 0) ? 0 : m - 1, $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
